// File: rtl/pulse_pkg.sv
// Edge-mode encoding and sizing helpers shared by the pulse conditioner.
package pulse_pkg;

  typedef logic [1:0] edge_mode_t;

  localparam edge_mode_t EDGE_RISE = 2'd0;
  localparam edge_mode_t EDGE_FALL = 2'd1;
  localparam edge_mode_t EDGE_BOTH = 2'd2;

  // Decide whether a level transition is one this channel reports.
  function automatic logic edge_qualify(edge_mode_t mode, logic rise, logic fall);
    logic q;
    q = 1'b0;
    case (mode)
      EDGE_RISE: q = rise;
      EDGE_FALL: q = fall;
      EDGE_BOTH: q = rise | fall;
      default:   q = 1'b0;
    endcase
    return q;
  endfunction

  function automatic int max_int(int a, int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pulse_chan.sv
// One conditioner channel: synchroniser, counter debouncer, edge pulse and
// optional auto-repeat (built only when PULSE_AUTOREPEAT_EN is defined).
module pulse_chan
  import pulse_pkg::*;
#(
  parameter int         SYNC_STAGES     = 2,
  parameter int         DEBOUNCE_CYCLES = 4,
  parameter edge_mode_t EDGE_MODE       = EDGE_RISE,
  parameter int         REPEAT_DELAY    = 8,
  parameter int         REPEAT_PERIOD   = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic in_trig,
  output logic level,
  output logic pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 ||
      REPEAT_PERIOD < 1 || EDGE_MODE == 2'd3) begin : g_bad_cfg
    $error("pulse_chan: illegal parameter combination");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt;
  logic                   level_prev;
  logic                   s;
  logic                   rise;
  logic                   fall;
  logic                   rpt_fire;

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = level & ~level_prev;
  assign fall = ~level & level_prev;

  // rst_n is the legacy name of an active-high asynchronous reset.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      sync_q     <= '0;
      cnt        <= '0;
      level      <= 1'b0;
      level_prev <= 1'b0;
      pulse      <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], in_trig};
      level_prev <= level;
      pulse      <= en & (edge_qualify(EDGE_MODE, rise, fall) | rpt_fire);
      if (s == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= s;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

`ifdef PULSE_AUTOREPEAT_EN
  localparam int RW = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD) + 1);
  localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

  logic          rpt_active;
  logic          rpt_periodic;
  logic [RW-1:0] rpt_cnt;

  // Requiring level==1 here is what lets a release pulse win over a repeat.
  assign rpt_fire = rpt_active & level & en &
                    (rpt_cnt == (rpt_periodic ? PERIOD_LAST : DELAY_LAST));

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      rpt_active   <= 1'b0;
      rpt_periodic <= 1'b0;
      rpt_cnt      <= '0;
    end else if (rise && en && EDGE_MODE != EDGE_FALL) begin
      rpt_active   <= 1'b1;
      rpt_periodic <= 1'b0;
      rpt_cnt      <= '0;
    end else if (!level || !en) begin
      rpt_active   <= 1'b0;
      rpt_periodic <= 1'b0;
      rpt_cnt      <= '0;
    end else if (rpt_fire) begin
      rpt_periodic <= 1'b1;
      rpt_cnt      <= '0;
    end else if (rpt_active) begin
      rpt_cnt <= rpt_cnt + RW'(1);
    end
  end
`else
  assign rpt_fire = 1'b0;
`endif

endmodule

// File: rtl/pulse_conditioner.sv
// N-channel button/switch conditioner: one pulse_chan per input, en gates pulses.
// Auto-repeat is included when PULSE_AUTOREPEAT_EN is defined.
module pulse_conditioner
  import pulse_pkg::*;
#(
  parameter int         N_CH            = 4,
  parameter int         SYNC_STAGES     = 2,
  parameter int         DEBOUNCE_CYCLES = 4,
  parameter edge_mode_t EDGE_MODE       = EDGE_RISE,
  parameter int         REPEAT_DELAY    = 8,
  parameter int         REPEAT_PERIOD   = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [N_CH-1:0] in_trig,
  output logic [N_CH-1:0] out_level,
  output logic [N_CH-1:0] out_pulse
);

  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    pulse_chan #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .EDGE_MODE      (EDGE_MODE),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_chan (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (en),
      .in_trig(in_trig[i]),
      .level  (out_level[i]),
      .pulse  (out_pulse[i])
    );
  end

endmodule

// File: tb/tb_pulse_conditioner.sv
// Bench for pulse_conditioner: three DUTs (RISE/FALL/BOTH) on shared inputs,
// a window-based reference model with an expected queue, plus directed literal checks.
module tb_pulse_conditioner;
  import pulse_pkg::*;

  localparam int N   = 4;
  localparam int S   = 2;
  localparam int D   = 4;
  localparam int DLY = 8;
  localparam int PER = 4;
  localparam int W   = 4 * N;

`ifdef PULSE_AUTOREPEAT_EN
  localparam int HOLD_RISE = 7;
  localparam int HOLD_BOTH = 8;
`else
  localparam int HOLD_RISE = 1;
  localparam int HOLD_BOTH = 2;
`endif

  // ---------------- clock / reset / DUTs ----------------
  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic [N-1:0] in_trig;
  logic [N-1:0] lvl_r, lvl_f, lvl_b;
  logic [N-1:0] pul_r, pul_f, pul_b;

  always #5 clk = ~clk;

  pulse_conditioner #(.N_CH(N), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .EDGE_MODE(EDGE_RISE),
                      .REPEAT_DELAY(DLY), .REPEAT_PERIOD(PER)) dut_rise (
    .clk(clk), .rst_n(rst_n), .en(en), .in_trig(in_trig), .out_level(lvl_r), .out_pulse(pul_r));
  pulse_conditioner #(.N_CH(N), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .EDGE_MODE(EDGE_FALL),
                      .REPEAT_DELAY(DLY), .REPEAT_PERIOD(PER)) dut_fall (
    .clk(clk), .rst_n(rst_n), .en(en), .in_trig(in_trig), .out_level(lvl_f), .out_pulse(pul_f));
  pulse_conditioner #(.N_CH(N), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .EDGE_MODE(EDGE_BOTH),
                      .REPEAT_DELAY(DLY), .REPEAT_PERIOD(PER)) dut_both (
    .clk(clk), .rst_n(rst_n), .en(en), .in_trig(in_trig), .out_level(lvl_b), .out_pulse(pul_b));

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  logic [W-1:0] exp_q[$];
  int pcnt[3][N];
  int lcnt[N];
  int c1001 = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, got, want);
  endtask

  // ---------------- reference model ----------------
  // Level flips once the last D synchronised samples all disagree with it;
  // the synchronised sample before edge j (counted from reset) is raw sample j-S.
  bit hist[N][$];
  bit sq[N][$];
  bit mlv[N];
  bit mlv1[N];
  bit act[3][N];
  int base[3][N];

  task automatic model_step();
    logic [W-1:0] e;
    bit s_b, rise, fall, nl, q, rp;
    int j, d;
    e = '0;
    cyc++;
    if (rst_n) begin
      for (int ch = 0; ch < N; ch++) begin
        hist[ch].delete();
        sq[ch].delete();
        mlv[ch]  = 1'b0;
        mlv1[ch] = 1'b0;
        for (int m = 0; m < 3; m++) act[m][ch] = 1'b0;
      end
    end else begin
      for (int ch = 0; ch < N; ch++) begin
        j   = hist[ch].size();
        s_b = (j >= S) ? hist[ch][j-S] : 1'b0;
        hist[ch].push_back(in_trig[ch]);
        sq[ch].push_back(s_b);
        rise = mlv[ch] && !mlv1[ch];
        fall = !mlv[ch] && mlv1[ch];
        for (int m = 0; m < 3; m++) begin
          q  = (m == 0) ? rise : ((m == 1) ? fall : (rise || fall));
          rp = 1'b0;
          d  = 0;
`ifdef PULSE_AUTOREPEAT_EN
          if (m != 1) begin
            if (act[m][ch]) begin
              if (!(mlv[ch] && en)) act[m][ch] = 1'b0;
              else begin
                d  = cyc - base[m][ch];
                rp = (d == DLY) || (d > DLY && ((d - DLY) % PER) == 0);
              end
            end
            if (en && rise) begin
              act[m][ch]  = 1'b1;
              base[m][ch] = cyc;
            end
          end
`endif
          e[N*(m+1)+ch] = en && (q || rp);
        end
        nl = mlv[ch];
        if (sq[ch].size() >= D) begin
          nl = !mlv[ch];
          for (int i = 1; i <= D; i++)
            if (sq[ch][sq[ch].size()-i] == mlv[ch]) nl = mlv[ch];
        end
        e[ch]    = nl;
        mlv1[ch] = mlv[ch];
        mlv[ch]  = nl;
      end
    end
    exp_q.push_back(e);
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // ---------------- scoreboard compare ----------------
  initial forever begin
    logic [W-1:0] e, got;
    @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      e   = exp_q.pop_front();
      got = {pul_b, pul_f, pul_r, lvl_r};
      check("cycle_outputs", 32'(got), 32'(e));
      check("level_fall_dut", 32'(lvl_f), 32'(e[N-1:0]));
      check("level_both_dut", 32'(lvl_b), 32'(e[N-1:0]));
      for (int m = 0; m < 3; m++)
        for (int ch = 0; ch < N; ch++)
          if (got[N*(m+1)+ch]) pcnt[m][ch]++;
      for (int ch = 0; ch < N; ch++) if (lvl_r[ch]) lcnt[ch]++;
      if (pul_r == 4'b1001) c1001++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_counts();
    for (int m = 0; m < 3; m++)
      for (int ch = 0; ch < N; ch++) pcnt[m][ch] = 0;
    for (int ch = 0; ch < N; ch++) lcnt[ch] = 0;
    c1001 = 0;
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (n) @(negedge clk);
    rst_n = 1'b0;
  endtask

  task automatic wait_until(input int edge_no);
    while (cyc < edge_no) @(negedge clk);
  endtask

  task automatic pulse_input(input int ch, input int len, input int settle);
    @(negedge clk);
    in_trig[ch] = 1'b1;
    repeat (len) @(negedge clk);
    in_trig[ch] = 1'b0;
    repeat (settle) @(negedge clk);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int k, r;
    int rem[N];
    int rst_left;
    rst_n   = 1'b1;
    en      = 1'b1;
    in_trig = '0;
    clear_counts();
    do_reset(3);

    // reset state
    check("reset_level", 32'({lvl_r, lvl_f, lvl_b}), 32'(0));
    check("reset_pulse", 32'({pul_r, pul_f, pul_b}), 32'(0));

    // latency: sample at edge k -> level at k+5, pulse only after k+6
    @(negedge clk);
    in_trig[0] = 1'b1;
    k = cyc + 1;
    wait_until(k + 4);
    check("lat_level_early", 32'(lvl_r[0]), 32'(0));
    wait_until(k + 5);
    check("lat_level", 32'(lvl_r[0]), 32'(1));
    check("lat_pulse_early", 32'(pul_r[0]), 32'(0));
    wait_until(k + 6);
    check("lat_pulse", 32'(pul_r[0]), 32'(1));
    wait_until(k + 7);
    check("lat_pulse_one", 32'(pul_r[0]), 32'(0));
    in_trig[0] = 1'b0;
    repeat (12) @(negedge clk);

    // glitch: 3-cycle blip filtered, 4-cycle blip passes once
    clear_counts();
    pulse_input(1, 3, 15);
    check("glitch_level", 32'(lcnt[1]), 32'(0));
    check("glitch_pulse", 32'(pcnt[0][1]), 32'(0));
    clear_counts();
    pulse_input(1, 4, 15);
    check("blip4_pulse", 32'(pcnt[0][1]), 32'(1));

    // modes: short press then release
    clear_counts();
    pulse_input(2, 8, 15);
    check("mode_rise", 32'(pcnt[0][2]), 32'(1));
    check("mode_fall", 32'(pcnt[1][2]), 32'(1));
    check("mode_both", 32'(pcnt[2][2]), 32'(2));

    // en low across a press, then raised while held
    clear_counts();
    @(negedge clk);
    en = 1'b0;
    in_trig[3] = 1'b1;
    repeat (10) @(negedge clk);
    check("en_off_level", 32'(lvl_r[3]), 32'(1));
    en = 1'b1;
    repeat (12) @(negedge clk);
    check("en_off_rise", 32'(pcnt[0][3]), 32'(0));
    check("en_off_both", 32'(pcnt[2][3]), 32'(0));
    in_trig[3] = 1'b0;
    repeat (15) @(negedge clk);

    // simultaneous channels
    clear_counts();
    @(negedge clk);
    in_trig = 4'b1001;
    repeat (8) @(negedge clk);
    in_trig = 4'b0000;
    repeat (15) @(negedge clk);
    check("simul_1001", 32'(c1001), 32'(1));

    // reset mid-debounce with inputs held
    pulse_input(1, 1, 0);
    @(negedge clk);
    in_trig[1] = 1'b1;
    repeat (10) @(negedge clk);
    in_trig[0] = 1'b1;
    k = cyc + 1;
    wait_until(k + 3);
    rst_n = 1'b1;
    #1;
    check("rst_async_level", 32'({lvl_r, lvl_f, lvl_b}), 32'(0));
    check("rst_async_pulse", 32'({pul_r, pul_f, pul_b}), 32'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    r = cyc + 1;
    clear_counts();
    wait_until(r + 4);
    check("rst_rel_level_early", 32'(lvl_r[1:0]), 32'(0));
    wait_until(r + 5);
    check("rst_rel_level", 32'(lvl_r[1:0]), 32'(3));
    wait_until(r + 6);
    check("rst_rel_pulse", 32'(pul_r[1:0]), 32'(3));
    in_trig = '0;
    repeat (15) @(negedge clk);
    check("rst_rel_one_pulse", 32'(pcnt[0][0]), 32'(1));

    // long hold: auto-repeat when built in
    clear_counts();
    pulse_input(2, 30, 20);
    check("hold_rise", 32'(pcnt[0][2]), 32'(HOLD_RISE));
    check("hold_fall", 32'(pcnt[1][2]), 32'(1));
    check("hold_both", 32'(pcnt[2][2]), 32'(HOLD_BOTH));

    // randomized traffic against the model
    rst_left = 0;
    for (int ch = 0; ch < N; ch++) rem[ch] = $urandom_range(1, 12);
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (rst_n) begin
        if (rst_left == 0) rst_n = 1'b0;
        else rst_left--;
      end else if ($urandom_range(0, 299) == 0) begin
        rst_n    = 1'b1;
        rst_left = $urandom_range(0, 2);
      end
      if ($urandom_range(0, 39) == 0) en = ~en;
      for (int ch = 0; ch < N; ch++) begin
        if (rem[ch] == 0) begin
          in_trig[ch] = ~in_trig[ch];
          rem[ch] = ($urandom_range(0, 3) == 0) ? $urandom_range(10, 30) : $urandom_range(1, 6);
        end else begin
          rem[ch]--;
        end
      end
    end
    rst_n   = 1'b0;
    en      = 1'b1;
    in_trig = '0;
    repeat (20) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
